// File: rtl/eth_init_seq.sv
// Table-driven register init sequencer feeding the eth_cfg user config port.
// Optional cfg_resp checking on request completion: ETH_INIT_SEQ_RESP_CHK_EN.
module eth_init_seq #(
  parameter int TBL_ADDR_WIDTH = 6,
  parameter int REG_ADDR_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYC    = 4096,
  parameter int POLL_RETRY     = 255
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      start,
  output logic                      init_busy,
  output logic                      init_done,
  output logic                      init_err,
  output logic [1:0]                err_code,
  output logic [TBL_ADDR_WIDTH-1:0] err_idx,
  output logic [TBL_ADDR_WIDTH-1:0] tbl_addr,
  input  logic [1:0]                tbl_op,
  input  logic [REG_ADDR_WIDTH-1:0] tbl_reg_addr,
  input  logic [REG_DATA_WIDTH-1:0] tbl_reg_data,
  input  logic [REG_DATA_WIDTH-1:0] tbl_reg_mask,
  input  logic                      cfg_busy,
  input  logic [1:0]                cfg_resp,
  output logic                      cfg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] cfg_wr_addr,
  output logic [REG_DATA_WIDTH-1:0] cfg_wr_data,
  output logic                      cfg_rd_en,
  output logic [REG_ADDR_WIDTH-1:0] cfg_rd_addr,
  input  logic                      cfg_rd_vld,
  input  logic [REG_DATA_WIDTH-1:0] cfg_rd_data
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam int CNT_W = (REG_DATA_WIDTH > TO_W) ? REG_DATA_WIDTH : TO_W;
  localparam logic [CNT_W-1:0]          TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]                RETRY_MAX = 8'(POLL_RETRY);
  localparam logic [TBL_ADDR_WIDTH-1:0] IDX_LAST  = '1;

  localparam logic [1:0] OP_END = 2'b00, OP_WRITE = 2'b01, OP_POLL = 2'b10, OP_DELAY = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR_ISSUE, S_WR_WAIT,
    S_RD_ISSUE, S_RD_WAIT, S_DELAY, S_DONE, S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [REG_DATA_WIDTH-1:0] data_q, data_nxt, mask_q, mask_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [7:0]                retry_cnt, retry_nxt;
  logic                      seen_busy, seen_busy_nxt;
  logic                      rd_got, rd_got_nxt, rd_match, rd_match_nxt;

  logic                      init_busy_nxt, init_done_nxt, init_err_nxt;
  logic [1:0]                err_code_nxt;
  logic [TBL_ADDR_WIDTH-1:0] err_idx_nxt, tbl_addr_nxt;
  logic                      cfg_wr_en_nxt, cfg_rd_en_nxt;
  logic [REG_ADDR_WIDTH-1:0] cfg_wr_addr_nxt, cfg_rd_addr_nxt;
  logic [REG_DATA_WIDTH-1:0] cfg_wr_data_nxt;

  logic       adv, err_set;
  logic [1:0] err_set_code;
  logic       resp_bad;

`ifdef ETH_INIT_SEQ_RESP_CHK_EN
  assign resp_bad = (cfg_resp != 2'b00);
`else
  logic unused_resp;
  assign unused_resp = ^cfg_resp;
  assign resp_bad    = 1'b0;
`endif

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      cnt         <= '0;
      retry_cnt   <= '0;
      seen_busy   <= 1'b0;
      rd_got      <= 1'b0;
      rd_match    <= 1'b0;
      init_busy   <= 1'b0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
      err_code    <= '0;
      err_idx     <= '0;
      tbl_addr    <= '0;
      cfg_wr_en   <= 1'b0;
      cfg_wr_addr <= '0;
      cfg_wr_data <= '0;
      cfg_rd_en   <= 1'b0;
      cfg_rd_addr <= '0;
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      data_q      <= data_nxt;
      mask_q      <= mask_nxt;
      cnt         <= cnt_nxt;
      retry_cnt   <= retry_nxt;
      seen_busy   <= seen_busy_nxt;
      rd_got      <= rd_got_nxt;
      rd_match    <= rd_match_nxt;
      init_busy   <= init_busy_nxt;
      init_done   <= init_done_nxt;
      init_err    <= init_err_nxt;
      err_code    <= err_code_nxt;
      err_idx     <= err_idx_nxt;
      tbl_addr    <= tbl_addr_nxt;
      cfg_wr_en   <= cfg_wr_en_nxt;
      cfg_wr_addr <= cfg_wr_addr_nxt;
      cfg_wr_data <= cfg_wr_data_nxt;
      cfg_rd_en   <= cfg_rd_en_nxt;
      cfg_rd_addr <= cfg_rd_addr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    addr_nxt        = addr_q;
    data_nxt        = data_q;
    mask_nxt        = mask_q;
    cnt_nxt         = cnt;
    retry_nxt       = retry_cnt;
    seen_busy_nxt   = seen_busy;
    rd_got_nxt      = rd_got;
    rd_match_nxt    = rd_match;
    init_done_nxt   = init_done;
    init_err_nxt    = init_err;
    err_code_nxt    = err_code;
    err_idx_nxt     = err_idx;
    tbl_addr_nxt    = tbl_addr;
    cfg_wr_en_nxt   = 1'b0;
    cfg_wr_addr_nxt = cfg_wr_addr;
    cfg_wr_data_nxt = cfg_wr_data;
    cfg_rd_en_nxt   = 1'b0;
    cfg_rd_addr_nxt = cfg_rd_addr;
    adv             = 1'b0;
    err_set         = 1'b0;
    err_set_code    = 2'd0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_FETCH;
          tbl_addr_nxt  = '0;
          init_done_nxt = 1'b0;
          init_err_nxt  = 1'b0;
          err_code_nxt  = '0;
          err_idx_nxt   = '0;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        addr_nxt  = tbl_reg_addr;
        data_nxt  = tbl_reg_data;
        mask_nxt  = tbl_reg_mask;
        cnt_nxt   = '0;
        retry_nxt = '0;
        case (tbl_op)
          OP_END: begin
            state_nxt     = S_DONE;
            init_done_nxt = 1'b1;
          end
          OP_WRITE: state_nxt = S_WR_ISSUE;
          OP_POLL:  state_nxt = S_RD_ISSUE;
          OP_DELAY: state_nxt = S_DELAY;
        endcase
      end
      // Issue only once downstream is idle; the wait is bounded by the same timeout.
      S_WR_ISSUE: begin
        if (!cfg_busy) begin
          cfg_wr_en_nxt   = 1'b1;
          cfg_wr_addr_nxt = addr_q;
          cfg_wr_data_nxt = data_q;
          cnt_nxt         = '0;
          seen_busy_nxt   = 1'b0;
          state_nxt       = S_WR_WAIT;
        end else if (cnt == TO_LAST) begin
          err_set      = 1'b1;
          err_set_code = 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WR_WAIT: begin
        if (cfg_busy) seen_busy_nxt = 1'b1;
        if (seen_busy && !cfg_busy) begin
          if (resp_bad) begin
            err_set      = 1'b1;
            err_set_code = 2'd3;
          end else begin
            adv = 1'b1;
          end
        end else if (cnt == TO_LAST) begin
          err_set      = 1'b1;
          err_set_code = 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RD_ISSUE: begin
        if (!cfg_busy) begin
          cfg_rd_en_nxt   = 1'b1;
          cfg_rd_addr_nxt = addr_q;
          cnt_nxt         = '0;
          rd_got_nxt      = 1'b0;
          rd_match_nxt    = 1'b0;
          state_nxt       = S_RD_WAIT;
        end else if (cnt == TO_LAST) begin
          err_set      = 1'b1;
          err_set_code = 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RD_WAIT: begin
        if (cfg_rd_vld) begin
          rd_got_nxt   = 1'b1;
          rd_match_nxt = (((cfg_rd_data ^ data_q) & mask_q) == '0);
        end
        if (rd_got && !cfg_busy) begin
          if (resp_bad) begin
            err_set      = 1'b1;
            err_set_code = 2'd3;
          end else if (rd_match) begin
            adv = 1'b1;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_nxt = retry_cnt + 8'd1;
            cnt_nxt   = '0;
            state_nxt = S_RD_ISSUE;
          end else begin
            err_set      = 1'b1;
            err_set_code = 2'd2;
          end
        end else if (cnt == TO_LAST) begin
          err_set      = 1'b1;
          err_set_code = 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      // A zero count still spends one cycle here.
      S_DELAY: begin
        if ((cnt + CNT_W'(1)) >= CNT_W'(data_q)) adv = 1'b1;
        else cnt_nxt = cnt + CNT_W'(1);
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (err_set) begin
      state_nxt    = S_ERR;
      init_err_nxt = 1'b1;
      err_code_nxt = err_set_code;
      err_idx_nxt  = tbl_addr;
    end else if (adv) begin
      if (tbl_addr == IDX_LAST) begin
        state_nxt     = S_DONE;
        init_done_nxt = 1'b1;
      end else begin
        tbl_addr_nxt = tbl_addr + TBL_ADDR_WIDTH'(1);
        state_nxt    = S_FETCH;
      end
    end

    init_busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
